// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), opcode-selected execute steps,
// HALT. Control strobes are decoded from the present-state register each cycle.
module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic [4:0]  opcode,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        HIin,
  output logic        LOin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Outportin,
  output logic        CONin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Inportout,
  output logic        Cout,
  output logic        run
);

  localparam logic [4:0] OP_ADD = 5'b01011;

  typedef enum logic [5:0] {
    S_RST, S_HALT, S_T0, S_T1, S_T2,
    R3_T3, R3_T4, R3_T5,
    IM_T3, IM_T4, IM_T5,
    LI_T3, LI_T4, LI_T5,
    LD_T3, LD_T4, LD_T5, LD_T6, LD_T7,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    MD_T3, MD_T4, MD_T5, MD_T6,
    NG_T3, NG_T4,
    BR_T3, BR_T4, BR_T5, BR_T6,
    JR_T3, IN_T3, OUT_T3, MFHI_T3, MFLO_T3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op_ir;

  assign op_ir = IR[31:27];

  always_comb begin
    state_d = S_T0;
    case (state_q)
      S_RST:   state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (op_ir <= 5'd10) state_d = R3_T3;
        else begin
          case (op_ir)
            5'd11, 5'd12, 5'd13: state_d = IM_T3;
            5'd14:               state_d = LD_T3;
            5'd15:               state_d = LI_T3;
            5'd16:               state_d = ST_T3;
            5'd17, 5'd18:        state_d = MD_T3;
            5'd19, 5'd20:        state_d = NG_T3;
            5'd21:               state_d = BR_T3;
            5'd22:               state_d = JR_T3;
            5'd24:               state_d = IN_T3;
            5'd25:               state_d = OUT_T3;
            5'd26:               state_d = MFHI_T3;
            5'd27:               state_d = MFLO_T3;
            5'd29:               state_d = S_HALT;
            default:             state_d = S_T0;   // nop and unused codes
          endcase
        end
      end
      R3_T3: state_d = R3_T4;
      R3_T4: state_d = R3_T5;
      IM_T3: state_d = IM_T4;
      IM_T4: state_d = IM_T5;
      LI_T3: state_d = LI_T4;
      LI_T4: state_d = LI_T5;
      LD_T3: state_d = LD_T4;
      LD_T4: state_d = LD_T5;
      LD_T5: state_d = LD_T6;
      LD_T6: state_d = LD_T7;
      ST_T3: state_d = ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: state_d = ST_T6;
      ST_T6: state_d = ST_T7;
      MD_T3: state_d = MD_T4;
      MD_T4: state_d = MD_T5;
      MD_T5: state_d = MD_T6;
      NG_T3: state_d = NG_T4;
      BR_T3: state_d = BR_T4;
      BR_T4: state_d = BR_T5;
      BR_T5: state_d = BR_T6;
      default: state_d = S_T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    {Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin} = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout} = '0;
    opcode = 5'b00000;
    run    = 1'b1;
    case (state_q)
      S_HALT: run = 1'b0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      R3_T3, IM_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      R3_T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op_ir; end
      IM_T4: begin Cout = 1'b1; Zin = 1'b1; opcode = op_ir; end
      R3_T5, IM_T5, LI_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      LI_T3, LD_T3, ST_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      LI_T4, LD_T4, ST_T4: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
      LD_T5, ST_T5: begin Zlowout = 1'b1; MARin = 1'b1; end
      LD_T6: begin Read = 1'b1; MDRin = 1'b1; end
      LD_T7: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      ST_T6: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      ST_T7: Write = 1'b1;
      MD_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      MD_T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op_ir; end
      MD_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
      MD_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      NG_T3: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op_ir; end
      NG_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      BR_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
      BR_T4: begin PCout = 1'b1; Yin = 1'b1; end
      BR_T5: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
      // Branch target only committed when the condition flag holds this cycle
      BR_T6: begin Zlowout = CON_FF; PCin = CON_FF; end
      JR_T3: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      IN_T3: begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      OUT_T3: begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
      MFHI_T3: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      MFLO_T3: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle
// against hand-written strobe tables.
module tb_control_unit;
  logic        Clock = 1'b0, clear = 1'b1, CON_FF = 1'b0;
  logic [31:0] IR = '0;
  logic Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout, run;
  logic [4:0]  opcode;
  logic [26:0] ctl;
  int n_tests = 0, n_fail = 0;

  localparam logic [26:0] READ = 27'd1 << 26, WRITE = 27'd1 << 25, INCPC = 27'd1 << 24,
    GRA = 27'd1 << 23, GRB = 27'd1 << 22, GRC = 27'd1 << 21, RIN = 27'd1 << 20,
    ROUT = 27'd1 << 19, BAOUT = 27'd1 << 18, HIIN = 27'd1 << 17, LOIN = 27'd1 << 16,
    YIN = 27'd1 << 15, ZIN = 27'd1 << 14, PCIN = 27'd1 << 13, IRIN = 27'd1 << 12,
    MARIN = 27'd1 << 11, MDRIN = 27'd1 << 10, OUTPIN = 27'd1 << 9, CONIN = 27'd1 << 8,
    HIOUT = 27'd1 << 7, LOOUT = 27'd1 << 6, ZHOUT = 27'd1 << 5, ZLOUT = 27'd1 << 4,
    PCOUT = 27'd1 << 3, MDROUT = 27'd1 << 2, INPOUT = 27'd1 << 1, COUT = 27'd1;
  localparam logic [26:0] F0 = PCOUT | MARIN, F1 = READ | MDRIN,
    F2 = MDROUT | IRIN | PCIN | INCPC;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .Read(Read), .Write(Write), .IncPC(IncPC), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Outportin(Outportin), .CONin(CONin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .Inportout(Inportout), .Cout(Cout), .run(run)
  );

  assign ctl = {Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin,
                Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin, HIout, LOout,
                Zhighout, Zlowout, PCout, MDRout, Inportout, Cout};

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; tick(); tick();
    n_tests++;
    if ({run, opcode, ctl} !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL reset_rst: got run=%b op=%b ctl=%h want run=1 op=0 ctl=0", run, opcode, ctl);
    end
    clear = 1'b0; tick();
    n_tests++;
    if ({run, opcode, ctl} !== {1'b1, 5'd0, F0}) begin
      n_fail++; $display("FAIL reset_t0: got run=%b op=%b ctl=%h want ctl=%h", run, opcode, ctl, F0);
    end
  endtask

  // Starts in T0; last table entry is the T0 that follows the instruction.
  task automatic test_andi();
    logic [26:0] e [7];
    logic [4:0]  o [7];
    IR = 32'h61080005;
    e = '{F0, F1, F2, GRB | ROUT | YIN, COUT | ZIN, ZLOUT | GRA | RIN, F0};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01100, 5'd0, 5'd0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL andi step%0d: got run=%b op=%b ctl=%h want op=%b ctl=%h", i, run, opcode, ctl, o[i], e[i]);
      end
    end
  endtask

  task automatic test_r3_sub();
    logic [26:0] e [7];
    logic [4:0]  o [7];
    IR = 32'h20000000;   // opcode 00100
    e = '{F0, F1, F2, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLOUT | GRA | RIN, F0};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00100, 5'd0, 5'd0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL r3 step%0d: got op=%b ctl=%h want op=%b ctl=%h", i, opcode, ctl, o[i], e[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [26:0] e [9];
    logic [4:0]  o [9];
    IR = 32'h70000000;
    e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN, ZLOUT | MARIN, READ | MDRIN,
          MDROUT | GRA | RIN, F0};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01011, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL ld step%0d: got op=%b ctl=%h want op=%b ctl=%h", i, opcode, ctl, o[i], e[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [26:0] e [8];
    logic [4:0]  o [8];
    IR = 32'h88000000;   // opcode 10001
    e = '{F0, F1, F2, GRA | ROUT | YIN, GRB | ROUT | ZIN, ZLOUT | LOIN, ZHOUT | HIIN, F0};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b10001, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL mul step%0d: got op=%b ctl=%h want op=%b ctl=%h", i, opcode, ctl, o[i], e[i]);
      end
    end
  endtask

  task automatic test_neg_in();
    logic [26:0] e [9];
    logic [4:0]  o [9];
    IR = 32'h98000000;   // neg 10011, then in 11000 back to back
    e = '{F0, F1, F2, GRB | ROUT | ZIN, ZLOUT | GRA | RIN, F0, F1, F2, INPOUT | GRA | RIN};
    o = '{5'd0, 5'd0, 5'd0, 5'b10011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      if (i == 5) IR = 32'hC0000000;
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL neg_in step%0d: got op=%b ctl=%h want op=%b ctl=%h", i, opcode, ctl, o[i], e[i]);
      end
    end
    tick();
    n_tests++;
    if (ctl !== F0) begin
      n_fail++; $display("FAIL neg_in_t0: got ctl=%h want %h", ctl, F0);
    end
  endtask

  task automatic test_br(input logic cond);
    logic [26:0] e [8];
    logic [4:0]  o [8];
    IR = 32'hA8000000; CON_FF = cond;
    e = '{F0, F1, F2, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN,
          cond ? (ZLOUT | PCIN) : 27'd0, F0};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b01011, 5'd0, 5'd0};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL br%0b step%0d: got op=%b ctl=%h want op=%b ctl=%h", cond, i, opcode, ctl, o[i], e[i]);
      end
    end
    CON_FF = 1'b0;
  endtask

  task automatic test_st_abort();
    logic [26:0] e [7];
    logic [4:0]  o [7];
    IR = 32'h80000000;
    e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN, ZLOUT | MARIN, GRA | ROUT | MDRIN};
    o = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b01011, 5'd0, 5'd0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, o[i], e[i]}) begin
        n_fail++; $display("FAIL st step%0d: got op=%b ctl=%h want op=%b ctl=%h", i, opcode, ctl, o[i], e[i]);
      end
    end
    clear = 1'b1; tick();
    n_tests++;
    if ({run, opcode, ctl} !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL st_abort_rst: got run=%b write=%b ctl=%h want run=1 ctl=0", run, Write, ctl);
    end
    clear = 1'b0; tick();
    n_tests++;
    if ({run, ctl} !== {1'b1, F0}) begin
      n_fail++; $display("FAIL st_abort_t0: got run=%b ctl=%h want ctl=%h", run, ctl, F0);
    end
  endtask

  task automatic test_unused();
    logic [26:0] e [4];
    IR = 32'hF8000000;
    e = '{F0, F1, F2, F0};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, opcode, ctl} !== {1'b1, 5'd0, e[i]}) begin
        n_fail++; $display("FAIL op11111 step%0d: got op=%b ctl=%h want ctl=%h", i, opcode, ctl, e[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [26:0] e [3];
    int bad;
    IR = 32'hE8000000;
    e = '{F0, F1, F2};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      n_tests++;
      if ({run, ctl} !== {1'b1, e[i]}) begin
        n_fail++; $display("FAIL halt_fetch step%0d: got run=%b ctl=%h want ctl=%h", i, run, ctl, e[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({run, opcode, ctl} !== 33'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL halt_hold: %0d of 20 cycles had run/strobes set, want 0", bad);
    end
    clear = 1'b1; tick();
    n_tests++;
    if ({run, opcode, ctl} !== {1'b1, 5'd0, 27'd0}) begin
      n_fail++; $display("FAIL halt_rst: got run=%b ctl=%h want run=1 ctl=0", run, ctl);
    end
    clear = 1'b0; tick();
    n_tests++;
    if ({run, ctl} !== {1'b1, F0}) begin
      n_fail++; $display("FAIL halt_t0: got run=%b ctl=%h want run=1 ctl=%h", run, ctl, F0);
    end
  endtask

  initial begin
    test_reset();
    test_andi();
    test_r3_sub();
    test_ld();
    test_mul();
    test_neg_in();
    test_br(1'b1);
    test_br(1'b0);
    test_unused();
    test_st_abort();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
